// File: rtl/mmcm_reconfig_sequencer.sv
// MMCM runtime reconfiguration: gate BUFGCEs, hold MMCM in reset, apply DRP read-modify-write
// table, release reset and wait for lock with timeout/retry.
module mmcm_reconfig_sequencer #(
    parameter int NUM_REGS     = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRP_TIMEOUT  = 63,
    parameter int MAX_RETRIES  = 3,
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [6:0]       tbl_addr,
    input  logic [15:0]      tbl_mask,
    input  logic [15:0]      tbl_data,
    output logic             drp_en,
    output logic             drp_we,
    output logic [6:0]       drp_addr,
    output logic [15:0]      drp_di,
    input  logic [15:0]      drp_do,
    input  logic             drp_rdy,
    output logic             mmcm_rst,
    input  logic             mmcm_locked,
    output logic             clk_enable
);
    localparam int LCK_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam int DRP_W = (DRP_TIMEOUT > 0) ? $clog2(DRP_TIMEOUT + 1) : 1;
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, GATE, RESET, READ, WAIT_RD, WRITE, WAIT_WR,
        RELEASE, WAIT_LOCK, RETRY, DONE, FAIL
    } state_t;

    state_t           state;
    logic             lock_meta, lock_sync;
    logic [DRP_W-1:0] drp_cnt;
    logic [LCK_W-1:0] lock_cnt;
    logic [RTY_W-1:0] retries;
    logic [1:0]       rst_cnt;
    logic [15:0]      rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lock_meta  <= 1'b0;
            lock_sync  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            tbl_idx    <= '0;
            drp_en     <= 1'b0;
            drp_we     <= 1'b0;
            drp_addr   <= '0;
            drp_di     <= '0;
            mmcm_rst   <= 1'b0;
            clk_enable <= 1'b0;
            drp_cnt    <= '0;
            lock_cnt   <= '0;
            retries    <= '0;
            rst_cnt    <= '0;
            rd_data    <= '0;
        end else begin
            lock_meta <= mmcm_locked;
            lock_sync <= lock_meta;
            drp_en    <= 1'b0;
            drp_we    <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    // A failed reconfiguration keeps the downstream clocks gated.
                    clk_enable <= lock_sync & ~error;
                    if (start) begin
                        state      <= GATE;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        clk_enable <= 1'b0;
                        retries    <= '0;
                    end
                end
                GATE: begin
                    mmcm_rst <= 1'b1;
                    state    <= RESET;
                end
                RESET: begin
                    tbl_idx <= '0;
                    state   <= READ;
                end
                READ: begin
                    drp_en   <= 1'b1;
                    drp_addr <= tbl_addr;
                    drp_cnt  <= '0;
                    state    <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (drp_rdy) begin
                        rd_data <= drp_do;
                        state   <= WRITE;
                    end else if (drp_cnt == DRP_W'(DRP_TIMEOUT)) begin
                        error      <= 1'b1;
                        busy       <= 1'b0;
                        mmcm_rst   <= 1'b0;
                        clk_enable <= 1'b0;
                        state      <= FAIL;
                    end else begin
                        drp_cnt <= drp_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    drp_en   <= 1'b1;
                    drp_we   <= 1'b1;
                    drp_addr <= tbl_addr;
                    drp_di   <= (rd_data & tbl_mask) | tbl_data;
                    drp_cnt  <= '0;
                    state    <= WAIT_WR;
                end
                WAIT_WR: begin
                    if (drp_rdy) begin
                        if (tbl_idx == IDX_W'(NUM_REGS - 1)) begin
                            state <= RELEASE;
                        end else begin
                            tbl_idx <= tbl_idx + 1'b1;
                            state   <= READ;
                        end
                    end else if (drp_cnt == DRP_W'(DRP_TIMEOUT)) begin
                        error      <= 1'b1;
                        busy       <= 1'b0;
                        mmcm_rst   <= 1'b0;
                        clk_enable <= 1'b0;
                        state      <= FAIL;
                    end else begin
                        drp_cnt <= drp_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    mmcm_rst <= 1'b0;
                    lock_cnt <= '0;
                    state    <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // Counter stops at the timeout value, so it never wraps.
                    if (lock_sync) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (lock_cnt == LCK_W'(LOCK_TIMEOUT)) begin
                        if (retries < RTY_W'(MAX_RETRIES)) begin
                            retries  <= retries + 1'b1;
                            mmcm_rst <= 1'b1;
                            rst_cnt  <= '0;
                            state    <= RETRY;
                        end else begin
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            mmcm_rst   <= 1'b0;
                            clk_enable <= 1'b0;
                            state      <= FAIL;
                        end
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                RETRY: begin
                    // Four cycles of reset: minimum MMCM RST width up to 250 MHz.
                    if (rst_cnt == 2'd3) begin
                        mmcm_rst <= 1'b0;
                        state    <= RELEASE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                DONE: begin
                    clk_enable <= 1'b1;
                    state      <= IDLE;
                end
                FAIL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmcm_reconfig_sequencer.sv
// Directed bench: DRP slave and MMCM lock models, DRP write scoreboard, immediate-assertion checks.
module tb_mmcm_reconfig_sequencer;
    localparam int NUM_REGS     = 2;
    localparam int LOCK_TIMEOUT = 100;
    localparam int DRP_TIMEOUT  = 15;
    localparam int MAX_RETRIES  = 3;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [0:0]  tbl_idx;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_mask, tbl_data;
    logic        drp_en, drp_we;
    logic [6:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0;
    logic        drp_rdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked;
    logic        clk_enable;

    int n_chk = 0;
    int n_fail = 0;
    wr_t sb[$];

    // Stimulus controls for the models.
    logic        drp_mute = 1'b0;
    int          rdy_dly = 3;
    logic [15:0] rd_val = 16'hFFFF;
    int          lock_attempt = 0;
    int          lock_delay = 10;
    logic        lock_ovr_en = 1'b0;
    logic        lock_ovr_val = 1'b0;

    mmcm_reconfig_sequencer #(
        .NUM_REGS(NUM_REGS), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .DRP_TIMEOUT(DRP_TIMEOUT), .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_mask(tbl_mask), .tbl_data(tbl_data),
        .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_rdy(drp_rdy), .mmcm_rst(mmcm_rst),
        .mmcm_locked(mmcm_locked), .clk_enable(clk_enable)
    );

    always #5 clk = ~clk;

    assign tbl_addr = (tbl_idx == 1'b0) ? 7'h08    : 7'h09;
    assign tbl_mask = (tbl_idx == 1'b0) ? 16'h1000 : 16'hFC00;
    assign tbl_data = (tbl_idx == 1'b0) ? 16'h0041 : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // DRP slave: rdy pulse rdy_dly cycles after each enable, unless muted.
    int pend = 0;
    int acc_cnt = 0;
    always @(negedge clk) begin
        drp_do  <= rd_val;
        drp_rdy <= (pend == 1);
        if (drp_en && !drp_mute) pend <= rdy_dly;
        else if (pend > 0)       pend <= pend - 1;
        if (drp_en) acc_cnt <= acc_cnt + 1;
    end

    // MMCM lock model: locks lock_delay cycles into release number lock_attempt.
    logic model_lk = 1'b0;
    logic rst_d = 1'b0;
    int   attempt = 0;
    int   lk_cnt = 0;
    assign mmcm_locked = lock_ovr_en ? lock_ovr_val : model_lk;
    always @(negedge clk) begin
        rst_d <= mmcm_rst;
        if (start && !busy)          attempt <= 0;
        else if (rst_d && !mmcm_rst) attempt <= attempt + 1;
        if (mmcm_rst) begin
            lk_cnt   <= 0;
            model_lk <= 1'b0;
        end else begin
            if (lk_cnt < 1000) lk_cnt <= lk_cnt + 1;
            if (lock_attempt != 0 && attempt == lock_attempt && lk_cnt >= lock_delay)
                model_lk <= 1'b1;
        end
    end

    // Scoreboard: every DRP write must match the next expected entry, under MMCM reset.
    always @(negedge clk) begin
        if (drp_en && drp_we) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(sb.size()), 1);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("drp_wr_addr", 32'(drp_addr), 32'(e.addr));
                chk("drp_wr_data", 32'(drp_di), 32'(e.data));
                chk("drp_wr_rst", 32'(mmcm_rst), 1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic push_tbl();
        // Old value 0xFFFF: (0xFFFF & 0x1000) | 0x0041, (0xFFFF & 0xFC00) | 0x0000
        sb.push_back('{7'h08, 16'h1041});
        sb.push_back('{7'h09, 16'hFC00});
    endtask

    task automatic wait_end(input int maxc, output int n);
        n = 0;
        while (!(done || error) && n < maxc) begin
            cyc(1);
            n++;
        end
    endtask

    // Waits for done/error while measuring mmcm_rst pulses; flags retry pulses not 4 wide.
    task automatic count_rst_pulses(input int maxc, output int pulses, output int bad_w);
        int   n = 0;
        int   width = 0;
        logic prev = mmcm_rst;
        pulses = 0;
        bad_w  = 0;
        while (!(done || error) && n < maxc) begin
            cyc(1);
            n++;
            if (mmcm_rst) width++;
            else if (prev) begin
                pulses++;
                if (pulses > 1 && width != 4) bad_w++;
                width = 0;
            end
            prev = mmcm_rst;
        end
    endtask

    initial begin
        int n, k, pulses, bad_w, a0, extra, bz;

        // Reset values
        cyc(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_drp_en", 32'(drp_en), 0);
        chk("rst_drp_we", 32'(drp_we), 0);
        chk("rst_drp_addr", 32'(drp_addr), 0);
        chk("rst_drp_di", 32'(drp_di), 0);
        chk("rst_tbl_idx", 32'(tbl_idx), 0);
        chk("rst_mmcm_rst", 32'(mmcm_rst), 0);
        chk("rst_clk_enable", 32'(clk_enable), 0);
        rst = 1'b0;
        cyc(1);

        // IDLE: clk_enable follows synchronized lock, loss of lock only gates
        lock_ovr_en = 1'b1;
        lock_ovr_val = 1'b1;
        cyc(4);
        chk("idle_ce_lock", 32'(clk_enable), 1);
        lock_ovr_val = 1'b0;
        cyc(4);
        chk("idle_ce_unlock", 32'(clk_enable), 0);
        chk("idle_no_auto", 32'(busy), 0);
        lock_ovr_en = 1'b0;

        // 1: full reconfiguration
        lock_attempt = 1;
        lock_delay = 10;
        push_tbl();
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        wait_end(500, n);
        chk("t1_done", 32'(done), 1);
        chk("t1_error", 32'(error), 0);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_idx_last", 32'(tbl_idx), NUM_REGS - 1);
        chk("t1_sb_empty", 32'(sb.size()), 0);
        cyc(1);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_ce", 32'(clk_enable), 1);

        // 2: DRP read never acknowledged
        drp_mute = 1'b1;
        lock_attempt = 0;
        pulse_start();
        n = 0;
        while (!drp_en && n < 20) begin cyc(1); n++; end
        chk("t2_rd_issued", 32'(drp_en), 1);
        k = 0;
        while (!error && k < 100) begin cyc(1); k++; end
        chk("t2_err_latency", k, DRP_TIMEOUT + 1);
        chk("t2_error", 32'(error), 1);
        chk("t2_busy", 32'(busy), 0);
        chk("t2_mmcm_rst", 32'(mmcm_rst), 0);
        chk("t2_ce", 32'(clk_enable), 0);
        drp_mute = 1'b0;
        cyc(1);

        // 3: never locks -> MAX_RETRIES 4-cycle pulses after the initial reset
        push_tbl();
        pulse_start();
        count_rst_pulses(2000, pulses, bad_w);
        chk("t3_pulses", pulses, MAX_RETRIES + 1);
        chk("t3_pulse_width", bad_w, 0);
        chk("t3_error", 32'(error), 1);
        chk("t3_ce", 32'(clk_enable), 0);
        chk("t3_busy", 32'(busy), 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t3_start_on_err_ign", 32'(busy), 0);
        chk("t3_err_sticky", 32'(error), 1);

        // 4: lock on second attempt; start in the IDLE cycle after error is accepted
        lock_attempt = 2;
        lock_delay = 20;
        push_tbl();
        pulse_start();
        chk("t4_accepted", 32'(busy), 1);
        chk("t4_err_clr", 32'(error), 0);
        count_rst_pulses(2000, pulses, bad_w);
        chk("t4_pulses", pulses, 2);
        chk("t4_pulse_width", bad_w, 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_error", 32'(error), 0);
        cyc(1);
        chk("t4_ce", 32'(clk_enable), 1);

        // 5: rst in WAIT_WR with rdy landing afterwards
        rdy_dly = 12;
        sb.push_back('{7'h08, 16'h1041});
        pulse_start();
        n = 0;
        while (!(drp_en && drp_we) && n < 50) begin cyc(1); n++; end
        chk("t5_wr_issued", 32'(drp_en && drp_we), 1);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_mmcm_rst", 32'(mmcm_rst), 0);
        chk("t5_drp_en", 32'(drp_en), 0);
        chk("t5_tbl_idx", 32'(tbl_idx), 0);
        chk("t5_drp_addr", 32'(drp_addr), 0);
        chk("t5_ce", 32'(clk_enable), 0);
        a0 = acc_cnt;
        cyc(20);
        chk("t5_no_access", acc_cnt - a0, 0);
        chk("t5_still_idle", 32'(busy), 0);
        chk("t5_sb_empty", 32'(sb.size()), 0);
        rdy_dly = 3;

        // 6: start while busy and on the done cycle is ignored
        lock_attempt = 1;
        lock_delay = 10;
        push_tbl();
        a0 = acc_cnt;
        pulse_start();
        cyc(4);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t6_busy", 32'(busy), 1);
        wait_end(500, n);
        chk("t6_done", 32'(done), 1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t6_done_start_ign", 32'(busy), 0);
        extra = 0;
        bz = 0;
        repeat (30) begin
            cyc(1);
            if (done) extra++;
            if (busy) bz++;
        end
        chk("t6_extra_done", extra, 0);
        chk("t6_extra_busy", bz, 0);
        chk("t6_drp_accesses", acc_cnt - a0, 2 * NUM_REGS);
        chk("t6_sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
